display_scan_driver: RTL and testbench

- Time-multiplexed scan controller for an 8-digit common-anode 7-segment display in the digital clock.
- Sits directly upstream of the 3-to-8 line decoder and generates its select inputs a2..a0 and its enables e1/e2_n/e3_n.
- Drives the shared active-low segment bus from a frame-coherent snapshot of eight BCD digits.
- Provides programmable dwell time, anti-ghosting blanking, per-digit enable masking and leading-zero suppression.

---
 rtl/display_scan_driver.sv | 151 +++++++++++++++
 tb/tb_display_scan_driver.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/display_scan_driver.sv
// Scan controller for an 8-digit common-anode 7-segment display behind a 3-to-8 decoder.
// Each slot blanks the decoder first, then lights one digit taken from a frame-coherent snapshot.
module display_scan_driver #(
  parameter int DIV   = 1000,
  parameter int BLANK = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] bcd,
  input  logic [7:0]  dp,
  input  logic [7:0]  digit_en,
  input  logic        lzs,
  output logic        a0,
  output logic        a1,
  output logic        a2,
  output logic        e1,
  output logic        e2_n,
  output logic        e3_n,
  output logic [6:0]  seg_n,
  output logic        dp_n,
  output logic        frame_start
);

  localparam int CW = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST      = CW'(DIV - 1);
  localparam logic [CW-1:0] BLANK_END = CW'(BLANK - 1);

  typedef enum logic {BLANKING, ON} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [2:0]    idx;
  logic          en_q;
  logic [31:0]   bcd_q;
  logic [7:0]    dp_q;
  logic          lzs_q;
  logic          load_pending;

  logic          boundary;
  logic          slot_start;
  logic          do_load;
  logic [2:0]    nxt;
  logic [2:0]    idx_n;
  logic          en_n;
  logic [31:0]   bcd_sel;
  logic [7:0]    dp_sel;
  logic          lzs_sel;

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = 7'h7F;
    endcase
    return s;
  endfunction

  // A digit is a leading zero when it and every more significant digit are zero.
  function automatic logic [6:0] digit_seg(input logic [31:0] digits, input logic lz,
                                           input logic [2:0] i);
    logic [31:0] upper;
    logic [6:0]  s;
    upper = digits >> {i, 2'b00};
    if (lz && (i != 3'd0) && (upper == 32'd0))
      s = 7'h7F;
    else
      s = seg_decode(digits[{i, 2'b00} +: 4]);
    return s;
  endfunction

  // Nearest enabled index above cur (wrapping); cur itself is the last candidate.
  function automatic logic [2:0] next_enabled(input logic [2:0] cur, input logic [7:0] en);
    logic [2:0] r;
    logic [2:0] c;
    r = cur;
    for (int k = 7; k >= 1; k--) begin
      c = cur + 3'(k);
      if (en[c]) r = c;
    end
    return r;
  endfunction

  always_comb begin
    boundary   = (cnt == LAST);
    nxt        = next_enabled(idx, digit_en);
    slot_start = load_pending | boundary;
    do_load    = load_pending | (boundary & (nxt <= idx));
    idx_n      = load_pending ? idx : nxt;
    en_n       = digit_en[idx_n];
    bcd_sel    = do_load ? bcd : bcd_q;
    dp_sel     = do_load ? dp : dp_q;
    lzs_sel    = do_load ? lzs : lzs_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= BLANKING;
      cnt          <= '0;
      idx          <= 3'd0;
      en_q         <= 1'b0;
      bcd_q        <= 32'd0;
      dp_q         <= 8'd0;
      lzs_q        <= 1'b0;
      load_pending <= 1'b1;
      {a2, a1, a0} <= 3'd0;
      e1           <= 1'b0;
      e2_n         <= 1'b1;
      e3_n         <= 1'b1;
      seg_n        <= 7'h7F;
      dp_n         <= 1'b1;
      frame_start  <= 1'b0;
    end else begin
      e2_n        <= 1'b0;
      e3_n        <= 1'b0;
      frame_start <= do_load;
      if (do_load) begin
        bcd_q        <= bcd;
        dp_q         <= dp;
        lzs_q        <= lzs;
        load_pending <= 1'b0;
      end
      // Slot start: decoder goes dark in the same cycle the select and segments move.
      if (slot_start) begin
        state        <= BLANKING;
        cnt          <= '0;
        idx          <= idx_n;
        en_q         <= en_n;
        e1           <= 1'b0;
        {a2, a1, a0} <= idx_n;
        seg_n        <= en_n ? digit_seg(bcd_sel, lzs_sel, idx_n) : 7'h7F;
        dp_n         <= ~dp_sel[idx_n];
      end else begin
        cnt <= cnt + 1'b1;
        if ((state == BLANKING) && (cnt == BLANK_END)) begin
          state <= ON;
          e1    <= en_q;
        end
      end
    end
  end

endmodule

// File: tb/tb_display_scan_driver.sv
// Bench for display_scan_driver: slot-level reference model compared every cycle,
// plus directed literal expectations for the scan scenarios.
module tb_display_scan_driver;
  localparam int DIV   = 8;
  localparam int BLANK = 2;
  localparam logic [6:0] SEG_TAB [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02,
                                          7'h78, 7'h00, 7'h10, 7'h7F, 7'h7F, 7'h7F, 7'h7F,
                                          7'h7F, 7'h7F};

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] bcd = 32'h76543210;
  logic [7:0]  dp = 8'h00;
  logic [7:0]  digit_en = 8'hFF;
  logic        lzs = 1'b0;
  logic        a0, a1, a2, e1, e2_n, e3_n, dp_n, frame_start;
  logic [6:0]  seg_n;

  int checks = 0;
  int failures = 0;
  int t = 0;

  always #5 clk = ~clk;

  display_scan_driver #(.DIV(DIV), .BLANK(BLANK)) dut (
    .clk(clk), .rst(rst), .bcd(bcd), .dp(dp), .digit_en(digit_en), .lzs(lzs),
    .a0(a0), .a1(a1), .a2(a2), .e1(e1), .e2_n(e2_n), .e3_n(e3_n),
    .seg_n(seg_n), .dp_n(dp_n), .frame_start(frame_start)
  );

  // Reference model: slot position, snapshot and pending-load flag.
  bit          m_armed = 0;
  bit          m_live = 0;
  bit          m_lp = 1;
  bit          m_fs = 0;
  bit          m_en = 0;
  int          m_cnt = 0;
  logic [2:0]  m_idx = 3'd0;
  logic [31:0] m_bcd = 32'd0;
  logic [7:0]  m_dp = 8'd0;
  bit          m_lzs = 0;

  function automatic logic [2:0] m_next(input logic [2:0] cur, input logic [7:0] en);
    logic [2:0] c;
    for (int k = 1; k <= 8; k++) begin
      c = cur + 3'(k % 8);
      if (en[c]) return c;
    end
    return cur;
  endfunction

  function automatic logic [6:0] m_seg(input logic [31:0] d, input bit lz, input logic [2:0] i);
    int n;
    n = int'(i);
    if (lz && n >= 1 && (d >> (4 * n)) == 32'd0) return 7'h7F;
    return SEG_TAB[d[4*n +: 4]];
  endfunction

  always @(posedge clk) begin
    logic [2:0] nx;
    bit load;
    if (rst) begin
      m_armed = 1; m_live = 0; m_lp = 1; m_fs = 0; m_en = 0; m_cnt = 0;
      m_idx = 3'd0; m_bcd = 32'd0; m_dp = 8'd0; m_lzs = 0;
    end else begin
      m_live = 1;
      nx = m_next(m_idx, digit_en);
      load = m_lp || (m_cnt == DIV - 1 && nx <= m_idx);
      if (m_lp) begin
        m_cnt = 0; m_en = digit_en[m_idx];
      end else if (m_cnt == DIV - 1) begin
        m_cnt = 0; m_idx = nx; m_en = digit_en[nx];
      end else begin
        m_cnt = m_cnt + 1;
      end
      m_fs = load;
      if (load) begin
        m_bcd = bcd; m_dp = dp; m_lzs = lzs; m_lp = 0;
      end
    end
  end

  function automatic logic [14:0] m_expect();
    logic [6:0] s;
    if (!m_live) return {3'd0, 1'b0, 1'b1, 1'b1, 7'h7F, 1'b1, 1'b0};
    s = m_en ? m_seg(m_bcd, m_lzs, m_idx) : 7'h7F;
    return {m_idx, m_en && (m_cnt >= BLANK), 1'b0, 1'b0, s, ~m_dp[m_idx], m_fs};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s t=%0d actual=%0h required=%0h", name, t, act, req);
    end
  endtask

  logic [2:0] prev_a;
  logic [6:0] prev_seg;
  bit         have_prev = 0;

  task automatic cmp_cycle();
    if (m_armed) begin
      check("model", 32'({a2, a1, a0, e1, e2_n, e3_n, seg_n, dp_n, frame_start}),
            32'(m_expect()));
      if (have_prev && (({a2, a1, a0} != prev_a) || (seg_n != prev_seg)))
        check("e1_on_change", 32'(e1), 32'd0);
      prev_a = {a2, a1, a0};
      prev_seg = seg_n;
      have_prev = 1;
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      t++;
      cmp_cycle();
    end
  endtask

  task automatic goto(input int target);
    step(target - t);
  endtask

  task automatic check_reset_values();
    check("rst_a", 32'({a2, a1, a0}), 32'd0);
    check("rst_e", 32'({e1, e2_n, e3_n}), 32'b011);
    check("rst_seg", 32'(seg_n), 32'h7F);
    check("rst_dp_fs", 32'({dp_n, frame_start}), 32'b10);
  endtask

  // Leaves the bench at cycle 0: the first non-reset cycle, where the snapshot loads.
  task automatic do_reset();
    rst = 1'b1;
    step(2);
    check_reset_values();
    rst = 1'b0;
    step(1);
    t = 0;
    check("start_fs", 32'(frame_start), 32'd1);
    check("start_a", 32'({a2, a1, a0}), 32'd0);
  endtask

  logic [6:0] lz_exp [8];

  initial begin
    // Full scan, all digits enabled.
    do_reset();
    check("d0_seg", 32'(seg_n), 32'h40);
    goto(1);  check("blank_e1", 32'(e1), 32'd0); check("fs_once", 32'(frame_start), 32'd0);
    goto(2);  check("on_e1_first", 32'(e1), 32'd1);
    goto(7);  check("on_e1_last", 32'(e1), 32'd1);
    goto(8);  check("slot1_a", 32'({a2, a1, a0}), 32'd1); check("slot1_e1", 32'(e1), 32'd0);
    check("slot1_seg", 32'(seg_n), 32'h79);
    goto(24); check("d3_a", 32'({a2, a1, a0}), 32'd3); check("d3_seg", 32'(seg_n), 32'h30);
    goto(56); check("d7_seg", 32'(seg_n), 32'h78);
    goto(63); check("pre_wrap_fs", 32'(frame_start), 32'd0);
    goto(64); check("wrap_fs", 32'(frame_start), 32'd1); check("wrap_a", 32'({a2, a1, a0}), 32'd0);

    // Mid-frame input change is held off until the next wrap.
    goto(70);  bcd = 32'h00000000;
    goto(128); check("zero_load_fs", 32'(frame_start), 32'd1); check("zero_d0", 32'(seg_n), 32'h40);
    goto(152); bcd = 32'h99999999;
    goto(160); check("hold_d4", 32'(seg_n), 32'h40);
    goto(184); check("hold_d7", 32'(seg_n), 32'h40);
    goto(192); check("nine_fs", 32'(frame_start), 32'd1); check("nine_d0", 32'(seg_n), 32'h10);
    goto(232); check("nine_d5", 32'(seg_n), 32'h10);

    // Sparse enable mask, then a mid-slot mask change taking effect at the boundary.
    bcd = 32'h76543210; digit_en = 8'b0010_0101;
    do_reset();
    goto(8);  check("mask_a2", 32'({a2, a1, a0}), 32'd2); check("mask_seg2", 32'(seg_n), 32'h24);
    goto(16); check("mask_a5", 32'({a2, a1, a0}), 32'd5); check("mask_seg5", 32'(seg_n), 32'h12);
    goto(24); check("mask_a0", 32'({a2, a1, a0}), 32'd0); check("mask_fs", 32'(frame_start), 32'd1);
    goto(26); digit_en = 8'hFF;
    goto(31); check("mask_hold", 32'({a2, a1, a0}), 32'd0);
    goto(32); check("mask_new_a1", 32'({a2, a1, a0}), 32'd1);

    // No digits enabled: index parks and the decoder never turns on.
    digit_en = 8'h00;
    do_reset();
    for (int c = 1; c <= 40; c++) begin
      goto(c);
      if (c % 8 == 4) begin
        check("none_a", 32'({a2, a1, a0}), 32'd0);
        check("none_e1", 32'(e1), 32'd0);
      end
    end

    // Leading-zero suppression and decimal point.
    digit_en = 8'hFF; lzs = 1'b1; bcd = 32'h00000120; dp = 8'h01;
    lz_exp = '{7'h40, 7'h24, 7'h79, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F};
    do_reset();
    for (int i = 0; i < 8; i++) begin
      goto(8 * i + 3);
      check("lzs_seg", 32'(seg_n), 32'(lz_exp[i]));
      check("lzs_dp", 32'(dp_n), (i == 0) ? 32'd0 : 32'd1);
    end
    bcd = 32'h00000000;
    for (int i = 0; i < 8; i++) begin
      goto(64 + 8 * i + 3);
      check("lzs_zero", 32'(seg_n), (i == 0) ? 32'h40 : 32'h7F);
    end

    // Non-decimal nibble shows blank.
    lzs = 1'b0; dp = 8'h00; bcd = 32'h0000000C;
    do_reset();
    goto(3);  check("nib_c", 32'(seg_n), 32'h7F);
    goto(11); check("nib_d1", 32'(seg_n), 32'h40);

    // Reset pulsed at cnt=5 of slot 3.
    bcd = 32'h76543210;
    do_reset();
    goto(29); check("mid_a", 32'({a2, a1, a0}), 32'd3); check("mid_e1", 32'(e1), 32'd1);
    rst = 1'b1;
    step(1);
    check_reset_values();
    rst = 1'b0;
    step(1);
    t = 0;
    check("restart_fs", 32'(frame_start), 32'd1);
    check("restart_a", 32'({a2, a1, a0}), 32'd0);
    goto(8);  check("restart_a1", 32'({a2, a1, a0}), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
